// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: job sequencer beside mem_ctrl. Loads operands, then
// alternates transfer and process phases one batch at a time until the
// batch target or end-of-data is reached. It drives the memory controller
// condition bus and the processing-unit start/done handshake. A per-phase
// watchdog and a host abort both leave through a one-cycle halt code.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | cond 000, waiting for start; latches length and batch target
// S_LOAD   | cond 100, operand store into RAM, waits for mc_done
// S_XFER   | cond 000, transfer phase, waits for mc_done then starts PU
// S_PROC   | cond 001, PU busy on one batch, waits for pu_done
// S_NEXT   | cond 010 for one cycle, advance to the next transfer
// S_FINISH | cond 000 for one cycle, job_done pulse
// S_HALT   | cond 010 for one cycle after timeout or abort, job_error set

module core_seq_ctrl #(
   parameter int TIMEOUT   = 255,
   parameter int MAX_BATCH = 15
) (
   input  logic       mc_clk,
   input  logic       mc_reset,
   input  logic       start,
   input  logic       abort,
   input  logic [5:0] job_length,
   input  logic [3:0] job_batches,
   input  logic       mc_done,
   input  logic       mc_data_done,
   input  logic       pu_done,
   output logic [2:0] mc_data_contition,
   output logic [5:0] mc_data_length,
   output logic       pu_start,
   output logic       busy,
   output logic       job_done,
   output logic       job_error,
   output logic [3:0] batch_cnt
);

   localparam logic [2:0] COND_IDLE  = 3'b000;
   localparam logic [2:0] COND_STORE = 3'b100;
   localparam logic [2:0] COND_HALT  = 3'b010;
   localparam logic [2:0] COND_PROC  = 3'b001;

   // The watchdog fires on the edge at which it would reach TIMEOUT, so a
   // stalled wait state is visible for exactly TIMEOUT cycles.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);
   localparam logic [3:0] BATCH_CAP = 4'(MAX_BATCH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_XFER,
      S_PROC,
      S_NEXT,
      S_FINISH,
      S_HALT
   } state_t;

   state_t     state;
   logic [3:0] target;
   logic [7:0] wdog;
   logic       eod;

   logic [3:0] batch_min;
   logic [3:0] batch_req;
   logic [3:0] cnt_inc;
   logic       wdog_hit;
   logic       eod_seen;
   logic       abort_ok;

   // Clamp the requested batch count, and precompute the decisions the FSM takes.
   always_comb begin
      batch_min = (job_batches > BATCH_CAP) ? BATCH_CAP : job_batches;
      batch_req = (batch_min == 4'd0) ? 4'd1 : batch_min;
      cnt_inc   = batch_cnt + 4'd1;
      wdog_hit  = (wdog == WDOG_LAST);
      // End-of-data counts even if it is first seen on the pu_done edge.
      eod_seen  = eod | mc_data_done;
      // A halt already in progress needs no second halt.
      abort_ok  = abort && (state != S_IDLE) && (state != S_HALT);
   end

   // Sequencer FSM with registered outputs, watchdog and sticky end-of-data flag.
   always_ff @(posedge mc_clk or posedge mc_reset) begin
      if (mc_reset) begin
         state             <= S_IDLE;
         mc_data_contition <= COND_IDLE;
         mc_data_length    <= 6'd0;
         pu_start          <= 1'b0;
         busy              <= 1'b0;
         job_done          <= 1'b0;
         job_error         <= 1'b0;
         batch_cnt         <= 4'd0;
         target            <= 4'd1;
         wdog              <= 8'd0;
         eod               <= 1'b0;
      end else begin
         pu_start <= 1'b0;
         job_done <= 1'b0;
         // Any branch that stays in a wait state overrides this with an increment;
         // every other branch is a state change and so clears the watchdog.
         wdog     <= 8'd0;

         if ((state == S_XFER || state == S_PROC || state == S_NEXT) && mc_data_done) begin
            eod <= 1'b1;
         end

         if (abort_ok) begin
            state             <= S_HALT;
            mc_data_contition <= COND_HALT;
            job_error         <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state             <= S_LOAD;
                     mc_data_contition <= COND_STORE;
                     mc_data_length    <= job_length;
                     target            <= batch_req;
                     batch_cnt         <= 4'd0;
                     job_error         <= 1'b0;
                     eod               <= 1'b0;
                     busy              <= 1'b1;
                  end
               end

               S_LOAD: begin
                  if (mc_done) begin
                     state             <= S_XFER;
                     mc_data_contition <= COND_IDLE;
                  end else if (wdog_hit) begin
                     state             <= S_HALT;
                     mc_data_contition <= COND_HALT;
                     job_error         <= 1'b1;
                  end else begin
                     wdog <= wdog + 8'd1;
                  end
               end

               S_XFER: begin
                  if (mc_done) begin
                     state             <= S_PROC;
                     mc_data_contition <= COND_PROC;
                     pu_start          <= 1'b1;
                  end else if (wdog_hit) begin
                     state             <= S_HALT;
                     mc_data_contition <= COND_HALT;
                     job_error         <= 1'b1;
                  end else begin
                     wdog <= wdog + 8'd1;
                  end
               end

               S_PROC: begin
                  if (pu_done) begin
                     batch_cnt <= cnt_inc;
                     if (cnt_inc == target || eod_seen) begin
                        state             <= S_FINISH;
                        mc_data_contition <= COND_IDLE;
                        job_done          <= 1'b1;
                     end else begin
                        state             <= S_NEXT;
                        mc_data_contition <= COND_HALT;
                     end
                  end else if (wdog_hit) begin
                     state             <= S_HALT;
                     mc_data_contition <= COND_HALT;
                     job_error         <= 1'b1;
                  end else begin
                     wdog <= wdog + 8'd1;
                  end
               end

               S_NEXT: begin
                  state             <= S_XFER;
                  mc_data_contition <= COND_IDLE;
               end

               S_FINISH: begin
                  state             <= S_IDLE;
                  mc_data_contition <= COND_IDLE;
                  busy              <= 1'b0;
               end

               S_HALT: begin
                  state             <= S_IDLE;
                  mc_data_contition <= COND_IDLE;
                  busy              <= 1'b0;
               end

               default: begin
                  state             <= S_IDLE;
                  mc_data_contition <= COND_IDLE;
                  busy              <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
